fetch_inst_buffer: RTL

Circular instruction buffer between fetch and the 3-wide dispatch stage. It accepts up to three IF_ID_PACKETs per cycle from fetch and presents the three oldest buffered instructions to dispatch as `dispatch_if_pkts`. It retires exactly the entries that dispatch accepts under its per-slot stall mask, and it discards all contents on a pipeline squash.

---
 rtl/fetch_inst_buffer_pkg.sv | 23 ++
 rtl/ibuf_lead_count.sv | 19 +
 rtl/fetch_inst_buffer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fetch_inst_buffer_pkg.sv
// Shared types for the fetch instruction buffer: the fetch/decode packet and
// the default buffer depth macro.
`ifndef SYS_IBUF_DEPTH
`define SYS_IBUF_DEPTH 8
`endif

package fetch_inst_buffer_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        bp_pred_taken;
  } IF_ID_PACKET;

  localparam int IBUF_SLOTS = 3;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'({1'b0, v[2]}) + 2'({1'b0, v[1]}) + 2'({1'b0, v[0]});
  endfunction

endpackage

// File: rtl/ibuf_lead_count.sv
// Counts how many slots, starting from bit 2, are valid and not stopped,
// ending at the first slot that fails.
module ibuf_lead_count (
  input  logic [2:0] valid,
  input  logic [2:0] stop,
  output logic [1:0] count
);

  logic [2:0] qual;

  always_comb begin
    qual  = valid & ~stop;
    count = 2'd0;
    if (qual[2]) count = 2'd1;
    if (qual[2] && qual[1]) count = 2'd2;
    if (qual[2] && qual[1] && qual[0]) count = 2'd3;
  end

endmodule

// File: rtl/fetch_inst_buffer.sv
// Circular instruction buffer between fetch and 3-wide dispatch.
// Optional same-cycle bypass when empty is enabled by defining IBUF_BYPASS_EN.
module fetch_inst_buffer
  import fetch_inst_buffer_pkg::*;
#(
  parameter int DEPTH = `SYS_IBUF_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   squash,
  input  IF_ID_PACKET [2:0]      fetch_pkts,
  output logic                   fetch_stall,
  output IF_ID_PACKET [2:0]      dispatch_if_pkts,
  input  logic [2:0]             dispatch_stall_mask,
  output logic [$clog2(DEPTH):0] ibuf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  IF_ID_PACKET      mem_q   [DEPTH];
  IF_ID_PACKET      wr_data [DEPTH];
  logic [DEPTH-1:0] wr_en;

  logic [1:0]        enq_span, enq_n, deq_raw, deq_n;
  logic [1:0]        enq_store, deq_store, skip, cmp_n;
  logic [2:0]        keep, out_vld;
  logic              enq_ok, bypass_act;
  IF_ID_PACKET [2:0] cmp;
  IF_ID_PACKET [2:0] pres;
  logic [PTR_W-1:0]  rd_idx, wr_idx;

  assign fetch_stall = count_q > CNT_W'(DEPTH - 3);
  assign ibuf_count  = count_q;
  assign enq_ok      = !fetch_stall && !squash;

  // Slot 2 never stops; a taken prediction in an older slot truncates the rest.
  ibuf_lead_count u_enq_lead (
    .valid (3'b111),
    .stop  ({1'b0,
             fetch_pkts[2].valid & fetch_pkts[2].bp_pred_taken,
             fetch_pkts[1].valid & fetch_pkts[1].bp_pred_taken}),
    .count (enq_span)
  );

  always_comb begin
    keep[2] = fetch_pkts[2].valid && (enq_span > 2'd0);
    keep[1] = fetch_pkts[1].valid && (enq_span > 2'd1);
    keep[0] = fetch_pkts[0].valid && (enq_span > 2'd2);
    enq_n   = popcount3(keep);
  end

  // Pack kept packets toward slot 2 so they occupy consecutive entries.
  always_comb begin
    cmp   = '0;
    cmp_n = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (keep[i]) begin
        cmp[2'd2 - cmp_n] = fetch_pkts[i];
        cmp_n             = cmp_n + 2'd1;
      end
    end
  end

`ifdef IBUF_BYPASS_EN
  assign bypass_act = (count_q == '0) && !squash;
`else
  assign bypass_act = 1'b0;
`endif

  always_comb begin
    pres   = '0;
    rd_idx = '0;
    for (int k = 0; k < IBUF_SLOTS; k++) begin
      rd_idx        = head_q + PTR_W'(2 - k);
      pres[k]       = mem_q[rd_idx];
      pres[k].valid = (count_q > CNT_W'(2 - k)) && !squash;
    end
    if (bypass_act) pres = cmp;
  end

  assign dispatch_if_pkts = pres;

  always_comb begin
    out_vld = {pres[2].valid, pres[1].valid, pres[0].valid};
  end

  ibuf_lead_count u_deq_lead (
    .valid (out_vld),
    .stop  (dispatch_stall_mask),
    .count (deq_raw)
  );

  assign deq_n = squash ? 2'd0 : deq_raw;

  // Bypassed packets consumed by dispatch never touch storage.
  always_comb begin
    if (bypass_act) begin
      skip      = deq_n;
      enq_store = enq_n - deq_n;
      deq_store = 2'd0;
    end else begin
      skip      = 2'd0;
      enq_store = enq_ok ? enq_n : 2'd0;
      deq_store = deq_n;
    end
  end

  always_comb begin
    wr_en   = '0;
    wr_data = '{default: '0};
    wr_idx  = '0;
    for (int j = 0; j < IBUF_SLOTS; j++) begin
      if (j < int'(enq_store)) begin
        wr_idx          = tail_q + PTR_W'(j);
        wr_en[wr_idx]   = 1'b1;
        wr_data[wr_idx] = cmp[2'(2 - int'(skip) - j)];
      end
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(deq_store);
    tail_d  = tail_q + PTR_W'(enq_store);
    count_d = count_q - CNT_W'(deq_store) + CNT_W'(enq_store);
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (wr_en[e]) mem_q[e] <= wr_data[e];
    end
  end

endmodule
